// File: rtl/serial_alu_pkg.sv
// Shared constants for the serial execute unit: ALU function codes, FSM states,
// shifter ops and flag bit positions.
package serial_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_S = 3;

  typedef enum logic [1:0] {SA_IDLE, SA_SHIFT, SA_DONE} sa_state_e;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_op_e;

  function automatic logic is_shift(input logic [3:0] fn);
    return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
  endfunction

  function automatic shift_op_e shift_op_of(input logic [3:0] fn);
    case (fn)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle and pulses done
// the cycle after the last step has landed in the working register.
module serial_shifter
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  shift_op_e                op,
  input  logic [WIDTH-1:0]         src,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic [WIDTH-1:0]         result,
  output logic                     done
);

  localparam int unsigned AW = $clog2(WIDTH);

  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [AW-1:0]    k;
  shift_op_e        op_q, op_d;
  logic             done_q, done_d;

  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    op_d   = op_q;
    done_d = 1'b0;
    k      = '0;
    if (start) begin
      work_d = src;
      rem_d  = amount;
      op_d   = op;
    end else if (rem_q != '0) begin
      // Compare in AW+1 bits so SHIFT_STEP == WIDTH still fits.
      if ({1'b0, rem_q} < (AW + 1)'(SHIFT_STEP)) k = rem_q;
      else                                       k = AW'(SHIFT_STEP);
      case (op_q)
        SH_SLL:  work_d = work_q << k;
        SH_SRL:  work_d = work_q >> k;
        default: work_d = $unsigned($signed(work_q) >>> k);
      endcase
      rem_d  = rem_q - k;
      done_d = (rem_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= SH_SLL;
      done_q <= 1'b0;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      done_q <= done_d;
    end
  end

  assign result = work_q;
  assign done   = done_q;

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic, iterative shifts,
// result and flags returned over a valid/ready handshake.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             sf,
  output logic             busy
);

  localparam int unsigned AW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [AW-1:0]    shamt;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res, sh_result;
  logic             alu_c, alu_v, sh_start, sh_done;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_S] = r[MSB];
    return f;
  endfunction

  assign shamt    = b[AW-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alufn)
      ALU_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: alu_res = WIDTH'(a < b);
      // Shifts only reach the single-cycle path with a zero amount.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    sh_start = 1'b0;
    case (state_q)
      SA_IDLE: begin
        if (in_valid) begin
          if (is_shift(alufn) && (shamt != '0)) begin
            sh_start = 1'b1;
            state_d  = SA_SHIFT;
          end else begin
            result_d = alu_res;
            flags_d  = pack_flags(alu_res, alu_c, alu_v);
            state_d  = SA_DONE;
          end
        end
      end
      SA_SHIFT: begin
        if (sh_done) begin
          result_d = sh_result;
          flags_d  = pack_flags(sh_result, 1'b0, 1'b0);
          state_d  = SA_DONE;
        end
      end
      SA_DONE: begin
        if (out_ready) state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SA_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  serial_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sh_start),
    .op     (shift_op_of(alufn)),
    .src    (a),
    .amount (shamt),
    .result (sh_result),
    .done   (sh_done)
  );

  assign in_ready  = (state_q == SA_IDLE);
  assign out_valid = (state_q == SA_DONE);
  assign busy      = (state_q == SA_SHIFT);
  assign result    = result_q;
  assign zf        = flags_q[FLAG_Z];
  assign cf        = flags_q[FLAG_C];
  assign vf        = flags_q[FLAG_V];
  assign sf        = flags_q[FLAG_S];

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: two instances (SHIFT_STEP 1 and 4) share stimulus.
module tb_serial_alu;
  import serial_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  alufn = ALU_ADD;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready1, out_valid1, busy1, zf1, cf1, vf1, sf1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, busy4, zf4, cf4, vf4, sf4;
  logic [31:0] result4;

  int n_checks = 0;
  int n_errors = 0;
  int lat1, lat4, bcnt;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .zf(zf1), .cf(cf1), .vf(vf1), .sf(sf1), .busy(busy1)
  );

  serial_alu #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .zf(zf4), .cf(cf4), .vf(vf4), .sf(sf4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles until each instance reaches DONE.
  task automatic do_op(input logic [3:0] fn, input logic [31:0] av, input logic [31:0] bv,
                       output int l1, output int l4, output int busy_cnt);
    l1 = 0;
    l4 = 0;
    busy_cnt = 0;
    @(negedge clk);
    alufn = fn; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 100 && (l1 == 0 || l4 == 0); cyc++) begin
      @(posedge clk); #1;
      if (busy1) busy_cnt++;
      if (out_valid1 && l1 == 0) l1 = cyc;
      if (out_valid4 && l4 == 0) l4 = cyc;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready1_after_release", {31'b0, in_ready1}, 32'd1);
    check("in_ready4_after_release", {31'b0, in_ready4}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'b0, in_ready1},  32'd1);
    check("rst_out_valid", {31'b0, out_valid1}, 32'd0);
    check("rst_busy",      {31'b0, busy1},      32'd0);
    check("rst_result",    result1,             32'd0);
    check("rst_flags",     {28'b0, zf1, cf1, vf1, sf1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, lat1, lat4, bcnt);
    check("add_ovf_lat",    lat1, 32'd1);
    check("add_ovf_result", result1, 32'h8000_0000);
    check("add_ovf_zcvs",   {28'b0, zf1, cf1, vf1, sf1}, 32'b0011);
    release_op();

    do_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, lat1, lat4, bcnt);
    check("add_carry_result", result1, 32'd0);
    check("add_carry_zcvs",   {28'b0, zf1, cf1, vf1, sf1}, 32'b1100);
    release_op();

    do_op(ALU_SUB, 32'd5, 32'd5, lat1, lat4, bcnt);
    check("sub_eq_result", result1, 32'd0);
    check("sub_eq_zcvs",   {28'b0, zf1, cf1, vf1, sf1}, 32'b1100);
    release_op();

    do_op(ALU_SUB, 32'h8000_0000, 32'd1, lat1, lat4, bcnt);
    check("sub_ovf_result", result1, 32'h7FFF_FFFF);
    check("sub_ovf_zcvs",   {28'b0, zf1, cf1, vf1, sf1}, 32'b0110);
    release_op();

    do_op(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, lat1, lat4, bcnt);
    check("sltu_result", result1, 32'd1);
    release_op();

    do_op(ALU_SLT, 32'd1, 32'hFFFF_FFFF, lat1, lat4, bcnt);
    check("slt_result", result1, 32'd0);
    release_op();

    do_op(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat1, lat4, bcnt);
    check("xor_result", result1, 32'hFF00_0FF0);
    release_op();

    do_op(4'b1001, 32'd5, 32'd3, lat1, lat4, bcnt);
    check("undef_result", result1, 32'd0);
    check("undef_zcvs",   {28'b0, zf1, cf1, vf1, sf1}, 32'b1000);
    check("undef_lat",    lat1, 32'd1);
    release_op();

    do_op(ALU_SRA, 32'h8000_0000, 32'd31, lat1, lat4, bcnt);
    check("sra31_lat_step1",  lat1, 32'd32);
    check("sra31_lat_step4",  lat4, 32'd9);
    check("sra31_busy_cnt",   bcnt, 32'd31);
    check("sra31_res_step1",  result1, 32'hFFFF_FFFF);
    check("sra31_res_step4",  result4, 32'hFFFF_FFFF);
    check("sra31_flags",      {28'b0, zf1, cf1, vf1, sf1}, 32'b0001);
    release_op();

    do_op(ALU_SRL, 32'h8000_0000, 32'd4, lat1, lat4, bcnt);
    check("srl4_lat_step1", lat1, 32'd5);
    check("srl4_lat_step4", lat4, 32'd2);
    check("srl4_res_step1", result1, 32'h0800_0000);
    check("srl4_res_step4", result4, 32'h0800_0000);
    release_op();

    do_op(ALU_SLL, 32'd1, 32'd5, lat1, lat4, bcnt);
    check("sll5_lat_step4", lat4, 32'd3);
    check("sll5_res_step1", result1, 32'h0000_0020);
    check("sll5_res_step4", result4, 32'h0000_0020);
    release_op();

    do_op(ALU_SLL, 32'd1, 32'd0, lat1, lat4, bcnt);
    check("sll0_lat",    lat1, 32'd1);
    check("sll0_result", result1, 32'd1);
    release_op();

    do_op(ALU_SLL, 32'd1, 32'd32, lat1, lat4, bcnt);
    check("sll32_lat",    lat1, 32'd1);
    check("sll32_result", result1, 32'd1);
    release_op();

    do_op(ALU_ADD, 32'd2, 32'd3, lat1, lat4, bcnt);
    check("hold_initial_result", result1, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      alufn = ALU_SUB;
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("hold_out_valid", {31'b0, out_valid1}, 32'd1);
      check("hold_result",    result1, 32'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op();
    @(posedge clk); #1;
    check("hold_no_accept", {31'b0, out_valid1}, 32'd0);

    @(negedge clk);
    alufn = ALU_SLL; a = 32'd1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midshift_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midshift_rst_in_ready",  {31'b0, in_ready1},  32'd1);
    check("midshift_rst_out_valid", {31'b0, out_valid1}, 32'd0);
    check("midshift_rst_busy",      {31'b0, busy1},      32'd0);
    check("midshift_rst_result",    result1,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midshift_no_late_result", {31'b0, out_valid1}, 32'd0);

    do_op(ALU_ADD, 32'd2, 32'd3, lat1, lat4, bcnt);
    check("post_rst_add_lat",    lat1, 32'd1);
    check("post_rst_add_result", result1, 32'd5);
    release_op();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
